// File: rtl/aes_inv_mixcol.sv
// aes_inv_mixcol: iterative AES InvMixColumns engine; AES_INV_MIXCOL_FWD_EN adds a forward MixColumns mode via port fwd
module aes_inv_mixcol #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
`ifdef AES_INV_MIXCOL_FWD_EN
  ,
  input  logic         fwd
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [1:0] LAST = 2'(4 / COLS_PER_CYCLE - 1);
  state_t r_state, w_next;
  logic [1:0] r_cnt;
  logic [127:0] r_work, w_work;
  logic w_fwd;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] col, input logic f);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = f
        ? (x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4])
        : (x8[i] ^ x4[i] ^ x2[i] ^ x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4]
           ^ x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4] ^ x8[(i+3)%4] ^ a[(i+3)%4]);
    return r;
  endfunction
`ifdef AES_INV_MIXCOL_FWD_EN
  logic r_fwd;
  always_ff @(posedge clk)
    if (rst) r_fwd <= 1'b0;
    else if (in_valid && in_ready) r_fwd <= fwd;
  assign w_fwd = r_fwd;
`else
  assign w_fwd = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    busy      = r_state != IDLE;
    out_state = out_valid ? r_work : '0;
    w_next = (r_state == IDLE && in_valid) ? BUSY
           : (r_state == BUSY && r_cnt == LAST) ? DONE
           : (r_state == DONE && out_ready) ? IDLE : r_state;
  end
  // only the column group addressed by r_cnt is rewritten each cycle
  always_comb begin
    w_work = r_work;
    for (int g = 0; g < COLS_PER_CYCLE; g++)
      w_work[127-32*(int'(r_cnt)*COLS_PER_CYCLE+g) -: 32] =
        mix(r_work[127-32*(int'(r_cnt)*COLS_PER_CYCLE+g) -: 32], w_fwd);
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_work <= '0;
      r_cnt  <= '0;
    end else if (in_valid && in_ready) begin
      r_work <= in_state;
      r_cnt  <= '0;
    end else if (r_state == BUSY) begin
      r_work <= w_work;
      r_cnt  <= r_cnt + 2'd1;
    end
endmodule

// File: tb/tb_aes_inv_mixcol.sv
// tb_aes_inv_mixcol: scoreboard bench over COLS_PER_CYCLE = 1, 2, 4 with directed FIPS-197 column vectors
module tb_aes_inv_mixcol;
  logic clk = 0, rst = 1;
  logic in_valid [3], in_ready [3], out_valid [3], out_ready [3], busy [3], fwd [3];
  logic [127:0] in_state [3], out_state [3];
  logic [127:0] exp_q [3][$];
  int acc_cyc [3], pv [3];
  int cyc = 0, n_vec = 0, n_err = 0;
  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_00000000_00000000;
  localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_00000000_00000000;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  genvar k;
  for (k = 0; k < 3; k++) begin : g_lane
    aes_inv_mixcol #(.COLS_PER_CYCLE(1 << k)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[k]), .in_ready(in_ready[k]), .in_state(in_state[k]),
      .out_valid(out_valid[k]), .out_ready(out_ready[k]), .out_state(out_state[k]),
      .busy(busy[k])
`ifdef AES_INV_MIXCOL_FWD_EN
      , .fwd(fwd[k])
`endif
    );
    always @(negedge clk) begin
      if (out_valid[k] && pv[k] == 0)
        chk($sformatf("latency_lane%0d", k), 128'(cyc - acc_cyc[k]), 128'(4 >> k));
      if (out_valid[k] && out_ready[k]) begin
        if (exp_q[k].size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out_lane%0d: got %h with no expected result queued", k, out_state[k]);
        end else chk($sformatf("out_state_lane%0d", k), out_state[k], exp_q[k].pop_front());
      end
      pv[k] = out_valid[k] ? 1 : 0;
    end
  end
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic send(input int l, input logic [127:0] d, input logic [127:0] e, input logic f, output int acc);
    int n = 0;
    @(negedge clk);
    in_valid[l] = 1; in_state[l] = d; fwd[l] = f;
    while (!in_ready[l] && n < 50) begin @(negedge clk); n++; end
    if (!in_ready[l]) begin
      chk("accept_timeout", 128'(in_ready[l]), 128'd1);
      in_valid[l] = 0; acc = -1;
      return;
    end
    exp_q[l].push_back(e);
    @(negedge clk);
    acc = cyc; acc_cyc[l] = cyc; in_valid[l] = 0;
  endtask
  task automatic wait_out(input int l);
    int n = 0;
    while (!out_valid[l] && n < 50) begin @(negedge clk); n++; end
    if (!out_valid[l]) chk("out_valid_timeout", 128'(out_valid[l]), 128'd1);
  endtask
  initial begin
    int a1, a2;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 0; in_state[i] = '0; out_ready[i] = 1; fwd[i] = 0; acc_cyc[i] = 0; pv[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_in_ready", 128'(in_ready[0]), 128'd1);
    chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("rst_busy", 128'(busy[0]), 128'd0);
    chk("rst_out_state", out_state[0], '0);
    for (int i = 0; i < 3; i++) begin
      send(i, V1, E1, 0, a1);
      wait_out(i);
      @(negedge clk);
    end
    out_ready[0] = 0;
    send(0, V1, E1, 0, a1);
    wait_out(0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
      chk("bp_out_state", out_state[0], E1);
      chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
      @(negedge clk);
    end
    out_ready[0] = 1;
    @(negedge clk);
    chk("release_in_ready", 128'(in_ready[0]), 128'd1);
    send(0, V2, E2, 0, a1);
    send(0, V2, E2, 0, a2);
    chk("b2b_spacing", 128'(a2 - a1), 128'd6);
    wait_out(0);
    @(negedge clk);
    send(0, V1, E1, 0, a1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_q[0].delete();
    chk("midrst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("midrst_in_ready", 128'(in_ready[0]), 128'd1);
    chk("midrst_out_state", out_state[0], '0);
    send(0, V1, E1, 0, a1);
    wait_out(0);
    @(negedge clk);
`ifdef AES_INV_MIXCOL_FWD_EN
    send(0, {4{32'hdb135345}}, {4{32'h8e4da1bc}}, 1, a1);
    wait_out(0);
    @(negedge clk);
    send(0, {4{32'h8e4da1bc}}, {4{32'hdb135345}}, 0, a1);
    wait_out(0);
    @(negedge clk);
`endif
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("queue_empty_lane%0d", i), 128'(exp_q[i].size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
